// File: rtl/cache_lru.sv
// rtl/cache_lru.sv - true-LRU replacement tracker; optional valid bits via CACHE_LRU_VALID_EN
module cache_lru #(
    parameter int NUM_SETS = 4,
    parameter int NUM_WAYS = 4,
    localparam int SET_W = $clog2(NUM_SETS),
    localparam int WAY_W = $clog2(NUM_WAYS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             victim_req,
    input  logic [SET_W-1:0] victim_set,
    output logic             victim_valid,
    output logic [WAY_W-1:0] victim_way,
    output logic             victim_free,
    input  logic             update_req,
    input  logic [SET_W-1:0] update_set,
    input  logic [WAY_W-1:0] update_way,
    input  logic             inval_req,
    input  logic [SET_W-1:0] inval_set,
    input  logic [WAY_W-1:0] inval_way,
    input  logic             flush_req
);

    localparam logic [WAY_W-1:0] AGE_MAX = WAY_W'(NUM_WAYS - 1);

    logic [WAY_W-1:0] age_q [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0] age_d [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0] touch_age;
    logic [WAY_W-1:0] inval_age;
    logic             inval_apply;

    logic             victim_valid_q;
    logic [WAY_W-1:0] victim_way_q;
    logic [WAY_W-1:0] age_way;
    logic [WAY_W-1:0] sel_way;

    assign touch_age   = age_q[update_set][update_way];
    assign inval_age   = age_q[inval_set][inval_way];
    // A same-set touch wins; the invalidate is dropped entirely.
    assign inval_apply = inval_req && !(update_req && (update_set == inval_set));

    always_comb begin
        age_d = age_q;
        for (int s = 0; s < NUM_SETS; s++) begin
            for (int i = 0; i < NUM_WAYS; i++) begin
                if (flush_req) begin
                    age_d[s][i] = WAY_W'(i);
                end else if (update_req && (update_set == SET_W'(s))) begin
                    if (update_way == WAY_W'(i))
                        age_d[s][i] = '0;
                    else if (age_q[s][i] < touch_age)
                        age_d[s][i] = age_q[s][i] + 1'b1;
                end else if (inval_apply && (inval_set == SET_W'(s))) begin
                    if (inval_way == WAY_W'(i))
                        age_d[s][i] = AGE_MAX;
                    else if (age_q[s][i] > inval_age)
                        age_d[s][i] = age_q[s][i] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        age_way = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (age_q[victim_set][i] == AGE_MAX)
                age_way = WAY_W'(i);
        end
    end

`ifdef CACHE_LRU_VALID_EN
    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0] valid_d [NUM_SETS];
    logic                free_hit;
    logic [WAY_W-1:0]    free_way;
    logic                victim_free_q;

    always_comb begin
        valid_d = valid_q;
        if (flush_req) begin
            for (int s = 0; s < NUM_SETS; s++)
                valid_d[s] = '0;
        end else begin
            if (update_req)
                valid_d[update_set][update_way] = 1'b1;
            if (inval_apply)
                valid_d[inval_set][inval_way] = 1'b0;
        end
    end

    // Descending scan so the lowest-index invalid way is the one kept.
    always_comb begin
        free_hit = 1'b0;
        free_way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!valid_q[victim_set][i]) begin
                free_hit = 1'b1;
                free_way = WAY_W'(i);
            end
        end
    end

    assign sel_way = free_hit ? free_way : age_way;

    always_ff @(posedge clock) begin
        if (reset) begin
            victim_free_q <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++)
                valid_q[s] <= '0;
        end else begin
            if (victim_req)
                victim_free_q <= free_hit;
            valid_q <= valid_d;
        end
    end

    assign victim_free = victim_free_q;
`else
    assign sel_way     = age_way;
    assign victim_free = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            victim_valid_q <= 1'b0;
            victim_way_q   <= '0;
            for (int s = 0; s < NUM_SETS; s++)
                for (int i = 0; i < NUM_WAYS; i++)
                    age_q[s][i] <= WAY_W'(i);
        end else begin
            victim_valid_q <= victim_req;
            if (victim_req)
                victim_way_q <= sel_way;
            age_q <= age_d;
        end
    end

    assign victim_valid = victim_valid_q;
    assign victim_way   = victim_way_q;

endmodule

// File: tb/tb_cache_lru.sv
// tb/tb_cache_lru.sv - randomized bench for cache_lru against a recency-list model
module tb_cache_lru;

    localparam int NS = 4;
    localparam int NW = 4;
    localparam int SET_W = $clog2(NS);
    localparam int WAY_W = $clog2(NW);

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             victim_req = 1'b0;
    logic [SET_W-1:0] victim_set = '0;
    logic             victim_valid;
    logic [WAY_W-1:0] victim_way;
    logic             victim_free;
    logic             update_req = 1'b0;
    logic [SET_W-1:0] update_set = '0;
    logic [WAY_W-1:0] update_way = '0;
    logic             inval_req = 1'b0;
    logic [SET_W-1:0] inval_set = '0;
    logic [WAY_W-1:0] inval_way = '0;
    logic             flush_req = 1'b0;

    cache_lru #(.NUM_SETS(NS), .NUM_WAYS(NW)) dut (
        .clock(clock), .reset(reset),
        .victim_req(victim_req), .victim_set(victim_set),
        .victim_valid(victim_valid), .victim_way(victim_way), .victim_free(victim_free),
        .update_req(update_req), .update_set(update_set), .update_way(update_way),
        .inval_req(inval_req), .inval_set(inval_set), .inval_way(inval_way),
        .flush_req(flush_req)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    // Model: per set, ways ordered from most to least recently used.
    int ord [NS][$];
    bit vld [NS][NW];
    int ev = 0, ew = 0, ef = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < NS; s++) begin
            ord[s] = {};
            for (int k = 0; k < NW; k++) begin
                ord[s].push_back(k);
                vld[s][k] = 1'b0;
            end
        end
    endtask

    task automatic model_move(input int s, input int w, input bit to_front);
        for (int k = 0; k < ord[s].size(); k++) begin
            if (ord[s][k] == w) begin
                ord[s].delete(k);
                break;
            end
        end
        if (to_front) ord[s].push_front(w);
        else          ord[s].push_back(w);
    endtask

    task automatic step(input bit r, input bit vr, input int vs,
                        input bit ur, input int us, input int uw,
                        input bit ir, input int is, input int iw, input bit fr);
        reset = r; victim_req = vr; victim_set = SET_W'(vs);
        update_req = ur; update_set = SET_W'(us); update_way = WAY_W'(uw);
        inval_req = ir; inval_set = SET_W'(is); inval_way = WAY_W'(iw);
        flush_req = fr;
        if (r) begin
            ev = 0; ew = 0; ef = 0;
        end else if (vr) begin
            ev = 1;
            ew = ord[vs][NW-1];
            ef = 0;
`ifdef CACHE_LRU_VALID_EN
            for (int w = NW - 1; w >= 0; w--) begin
                if (!vld[vs][w]) begin
                    ew = w;
                    ef = 1;
                end
            end
`endif
        end else begin
            ev = 0;
        end
        @(posedge clock);
        if (r || fr) begin
            model_clear();
        end else begin
            if (ur) begin
                model_move(us, uw, 1'b1);
                vld[us][uw] = 1'b1;
            end
            if (ir && !(ur && us == is)) begin
                model_move(is, iw, 1'b0);
                vld[is][iw] = 1'b0;
            end
        end
        #1;
        check_eq("victim_valid", int'(victim_valid), ev);
        check_eq("victim_way", int'(victim_way), ew);
        check_eq("victim_free", int'(victim_free), ef);
    endtask

    task automatic idle(input bit vr, input int vs);
        step(0, vr, vs, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_clear();
        @(posedge clock); #1;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset-state victim and single pulse
        idle(1, 2);
`ifndef CACHE_LRU_VALID_EN
        check_eq("plan_reset_way", int'(victim_way), 3);
`endif
        idle(0, 0);

        // Touch all ways of set 1, then invalidate way 2
        for (int w = 0; w < NW; w++) step(0, 0, 0, 1, 1, w, 0, 0, 0, 0);
        idle(1, 1);
`ifdef CACHE_LRU_VALID_EN
        check_eq("plan_full_way", int'(victim_way), 0);
        check_eq("plan_full_free", int'(victim_free), 0);
`endif
        step(0, 0, 0, 0, 0, 0, 1, 1, 2, 0);
        idle(1, 1);
        check_eq("plan_inval_way", int'(victim_way), 2);
        idle(1, 0);

        // Same-cycle update with victim request sees pre-update ages
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 1, 3, 0, 0, 0, 0);
        idle(1, 1);

        // Update and inval together: same set, then different sets
        step(0, 0, 0, 1, 1, 0, 1, 1, 1, 0);
        idle(1, 1);
        step(0, 0, 0, 1, 1, 2, 1, 3, 0, 0);
        idle(1, 1);
        idle(1, 3);

        // Back-to-back requests across reset and flush
        for (int c = 0; c < 8; c++)
            step(c == 4, 1, c % NS, c == 1, 0, 3, 0, 0, 0, c == 6);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(99) == 0, $urandom_range(1), $urandom_range(NS - 1),
                 $urandom_range(2) != 0, $urandom_range(NS - 1), $urandom_range(NW - 1),
                 $urandom_range(2) == 0, $urandom_range(NS - 1), $urandom_range(NW - 1),
                 $urandom_range(149) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
